branch_pht: RTL and testbench

- Parametrised pattern history table (PHT) of N-bit saturating counters for the pipeline branch predictor.
- Generalises the single 2-bit SNT/WNT/WT/ST predictor FSM to a table of 2^IDX_W counters with configurable counter width.
- Supports bimodal or gshare indexing via a global history register (GHR), and keeps saturating performance counters.
- Sits beside IF: IF issues a predict lookup; the resolving stage (EX) writes back the outcome through the update port.

---
 rtl/branch_pht_if.sv | 30 +++
 rtl/branch_pht.sv | 116 +++++++++++
 tb/tb_branch_pht.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_pht_if.sv
// Lookup/update bus between the fetch/resolve stages and the pattern history table.
// Both channels are valid-only with no ready: a lookup or update is consumed on
// every rising edge where its valid is high; the table never back-pressures.
interface branch_pht_if #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_out_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [CNT_W-1:0] pred_cnt;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_mispred;

    // Pipeline side: issues lookups and resolved outcomes.
    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
        input  pred_out_valid, pred_taken, pred_idx, pred_cnt
    );

    // Table side.
    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
        output pred_out_valid, pred_taken, pred_idx, pred_cnt
    );
endinterface

// File: rtl/branch_pht.sv
// Pattern history table of saturating counters with optional gshare indexing,
// a global history register and saturating update/mispredict counters.
module branch_pht #(
    parameter int CNT_W  = 2,
    parameter int IDX_W  = 6,
    parameter int HIST_W = 6,
    parameter bit GSHARE = 1,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    branch_pht_if.slave       bus,
    output logic [HIST_W-1:0] ghr,
    output logic [PERF_W-1:0] perf_upd,
    output logic [PERF_W-1:0] perf_miss
);
    localparam int               DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] TH    = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] INIT  = TH - 1'b1;
    localparam logic [CNT_W-1:0] MAX   = '1;

    logic [CNT_W-1:0] table_q [DEPTH];

    logic [IDX_W-1:0]  base_idx;
    logic [IDX_W-1:0]  look_idx;
    logic [CNT_W-1:0]  upd_cur;
    logic [CNT_W-1:0]  upd_next;
    logic [CNT_W-1:0]  look_cnt;
    logic [HIST_W:0]   ghr_shift;

    // PC bits outside the word-aligned index window do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0]};

    // Lookup index from the PC, optionally hashed with the pre-update history.
    always_comb begin
        base_idx = bus.pred_pc[IDX_W+1:2];
        look_idx = base_idx;
        if (GSHARE) begin
            look_idx = base_idx ^ IDX_W'(ghr);
        end
    end

    // Saturating next value for the entry being updated, no wrap at either end.
    always_comb begin
        upd_cur  = table_q[bus.upd_idx];
        upd_next = upd_cur;
        if (bus.upd_taken) begin
            if (upd_cur != MAX) upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - 1'b1;
        end
    end

    // Lookup value, bypassing a same-cycle update to the same entry.
    always_comb begin
        look_cnt = table_q[look_idx];
        if (bus.upd_valid && (bus.upd_idx == look_idx)) begin
            look_cnt = upd_next;
        end
    end

    // Shift-in of the resolved outcome; the extra MSB is dropped, which also covers HIST_W=1.
    assign ghr_shift = {ghr, bus.upd_taken};

    // Counter table and history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT;
            ghr <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT;
            ghr <= '0;
        end else if (bus.upd_valid) begin
            table_q[bus.upd_idx] <= upd_next;
            ghr                  <= ghr_shift[HIST_W-1:0];
        end
    end

    // Registered lookup result; payload holds while no lookup is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pred_out_valid <= 1'b0;
            bus.pred_taken     <= 1'b0;
            bus.pred_idx       <= '0;
            bus.pred_cnt       <= '0;
        end else if (clear) begin
            bus.pred_out_valid <= 1'b0;
            bus.pred_taken     <= 1'b0;
            bus.pred_idx       <= '0;
            bus.pred_cnt       <= '0;
        end else begin
            bus.pred_out_valid <= bus.pred_valid;
            if (bus.pred_valid) begin
                bus.pred_taken <= (look_cnt >= TH);
                bus.pred_idx   <= look_idx;
                bus.pred_cnt   <= look_cnt;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_upd  <= '0;
            perf_miss <= '0;
        end else if (clear) begin
            perf_upd  <= '0;
            perf_miss <= '0;
        end else if (bus.upd_valid) begin
            if (perf_upd != '1) perf_upd <= perf_upd + 1'b1;
            if (bus.upd_mispred && (perf_miss != '1)) perf_miss <= perf_miss + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: a bimodal instance (small perf counters) and a gshare instance.
module tb_branch_pht;
    logic clk;
    logic reset;
    logic b_clear;
    logic g_clear;
    logic [5:0]  b_ghr, g_ghr;
    logic [3:0]  b_perf_upd, b_perf_miss;
    logic [15:0] g_perf_upd, g_perf_miss;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected lookup result: {taken, idx[5:0], cnt[1:0]}
    logic [8:0] b_q[$];
    logic [8:0] g_q[$];

    branch_pht_if #(.IDX_W(6), .CNT_W(2)) bif ();
    branch_pht_if #(.IDX_W(6), .CNT_W(2)) gif ();

    branch_pht #(.CNT_W(2), .IDX_W(6), .HIST_W(6), .GSHARE(0), .PERF_W(4)) u_bim (
        .clk(clk), .reset(reset), .clear(b_clear), .bus(bif.slave),
        .ghr(b_ghr), .perf_upd(b_perf_upd), .perf_miss(b_perf_miss)
    );

    branch_pht #(.CNT_W(2), .IDX_W(6), .HIST_W(6), .GSHARE(1), .PERF_W(16)) u_gsh (
        .clk(clk), .reset(reset), .clear(g_clear), .bus(gif.slave),
        .ghr(g_ghr), .perf_upd(g_perf_upd), .perf_miss(g_perf_miss)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] e(input logic t, input logic [5:0] idx, input logic [1:0] cnt);
        return {t, idx, cnt};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.pred_valid = 0; bif.pred_pc = '0; bif.upd_valid = 0;
        bif.upd_idx = '0; bif.upd_taken = 0; bif.upd_mispred = 0;
        gif.pred_valid = 0; gif.pred_pc = '0; gif.upd_valid = 0;
        gif.upd_idx = '0; gif.upd_taken = 0; gif.upd_mispred = 0;
    endtask

    // One cycle of stimulus on one instance (g=1 gshare); expected lookup pushed when pv=1.
    task automatic cyc(input bit g, input bit pv, input logic [31:0] pc,
                       input bit uv, input logic [5:0] ui, input bit ut, input bit um,
                       input logic [8:0] exp);
        if (g) begin
            gif.pred_valid = pv; gif.pred_pc = pc; gif.upd_valid = uv;
            gif.upd_idx = ui; gif.upd_taken = ut; gif.upd_mispred = um;
            if (pv) g_q.push_back(exp);
        end else begin
            bif.pred_valid = pv; bif.pred_pc = pc; bif.upd_valid = uv;
            bif.upd_idx = ui; bif.upd_taken = ut; bif.upd_mispred = um;
            if (pv) b_q.push_back(exp);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Monitor: bimodal lookups
    always @(posedge clk) begin
        logic [8:0] exp_v;
        #2;
        if (bif.pred_out_valid) begin
            if (b_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pred_b: unexpected result 0x%0h", {bif.pred_taken, bif.pred_idx, bif.pred_cnt});
            end else begin
                exp_v = b_q.pop_front();
                chk("pred_b", {bif.pred_taken, bif.pred_idx, bif.pred_cnt}, exp_v);
            end
        end
    end

    // Monitor: gshare lookups
    always @(posedge clk) begin
        logic [8:0] exp_v;
        #2;
        if (gif.pred_out_valid) begin
            if (g_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pred_g: unexpected result 0x%0h", {gif.pred_taken, gif.pred_idx, gif.pred_cnt});
            end else begin
                exp_v = g_q.pop_front();
                chk("pred_g", {gif.pred_taken, gif.pred_idx, gif.pred_cnt}, exp_v);
            end
        end
    end

    initial begin : main
        logic [1:0] up_exp [4];
        logic [1:0] dn_exp [5];
        up_exp = '{2'd2, 2'd3, 2'd3, 2'd3};
        dn_exp = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

        idle_inputs();
        b_clear = 0; g_clear = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_b_valid", bif.pred_out_valid, 0);
        chk("rst_b_cnt", bif.pred_cnt, 0);
        chk("rst_b_ghr", b_ghr, 0);
        chk("rst_b_perf", b_perf_upd, 0);
        reset = 0;
        @(posedge clk); #1;

        // Reset-state lookup
        cyc(0, 1, 32'h40, 0, 0, 0, 0, e(0, 6'h10, 2'd1));

        // Gshare: history T,N,T with mispredicts 1,0,1
        cyc(1, 0, 0, 1, 6'h00, 1, 1, '0);
        cyc(1, 0, 0, 1, 6'h00, 0, 0, '0);
        cyc(1, 0, 0, 1, 6'h00, 1, 1, '0);
        chk("g_ghr_101", g_ghr, 6'h05);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, e(0, 6'h15, 2'd1));
        // Gshare collision: index from pre-update ghr, counter bypassed
        cyc(1, 1, 32'h40, 1, 6'h15, 1, 0, e(1, 6'h15, 2'd2));
        chk("g_ghr_1011", g_ghr, 6'h0B);
        chk("g_perf_upd", g_perf_upd, 4);
        chk("g_perf_miss", g_perf_miss, 2);
        cyc(1, 1, 32'h40, 0, 0, 0, 0, e(0, 6'h1B, 2'd1));

        // Bimodal saturation up on idx 5, then down with no wrap
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 6'd5, 1, 0, '0);
            cyc(0, 1, 32'h14, 0, 0, 0, 0, e(up_exp[i] >= 2, 6'd5, up_exp[i]));
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 6'd5, 0, 0, '0);
            cyc(0, 1, 32'h14, 0, 0, 0, 0, e(dn_exp[i] >= 2, 6'd5, dn_exp[i]));
        end
        chk("b_ghr_hist", b_ghr, 6'h20);
        chk("b_perf_upd9", b_perf_upd, 9);
        chk("b_perf_miss0", b_perf_miss, 0);

        // Collision bypass on idx 7 (was INIT)
        cyc(0, 1, 32'h1C, 1, 6'd7, 1, 0, e(1, 6'd7, 2'd2));
        cyc(0, 1, 32'h1C, 0, 0, 0, 0, e(1, 6'd7, 2'd2));
        chk("b_ghr_pre_clr", b_ghr, 6'h01);
        chk("b_perf_pre_clr", b_perf_upd, 10);

        // Clear dominates concurrent lookup and update
        b_clear = 1;
        bif.pred_valid = 1; bif.pred_pc = 32'h1C;
        bif.upd_valid = 1; bif.upd_idx = 6'd7; bif.upd_taken = 1; bif.upd_mispred = 1;
        @(posedge clk); #1;
        b_clear = 0;
        idle_inputs();
        chk("clr_valid", bif.pred_out_valid, 0);
        chk("clr_cnt", bif.pred_cnt, 0);
        chk("clr_ghr", b_ghr, 0);
        chk("clr_perf_upd", b_perf_upd, 0);
        chk("clr_perf_miss", b_perf_miss, 0);
        cyc(0, 1, 32'h1C, 0, 0, 0, 0, e(0, 6'd7, 2'd1));
        cyc(0, 1, 32'h14, 0, 0, 0, 0, e(0, 6'd5, 2'd1));

        // Perf counter saturation at 15
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 6'd9, 1, 1, '0);
        chk("sat_perf_upd", b_perf_upd, 15);
        chk("sat_perf_miss", b_perf_miss, 15);
        @(posedge clk); #1;
        chk("sat_perf_hold", b_perf_upd, 15);
        cyc(0, 1, 32'h24, 0, 0, 0, 0, e(1, 6'd9, 2'd3));

        // Asynchronous reset mid-operation drops the in-flight lookup
        bif.pred_valid = 1; bif.pred_pc = 32'h24;
        #2;
        reset = 1;
        #1;
        chk("arst_perf", b_perf_upd, 0);
        chk("arst_ghr", b_ghr, 0);
        chk("arst_cnt", bif.pred_cnt, 0);
        @(posedge clk); #1;
        chk("arst_drop", bif.pred_out_valid, 0);
        reset = 0;
        idle_inputs();

        repeat (3) @(posedge clk);
        #3;
        chk("b_q_drained", b_q.size(), 0);
        chk("g_q_drained", g_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
